// File: rtl/qtr_scan_sched_pkg.sv
// -----------------------------------------------------------------------------
// qtr_scan_sched_pkg
// Shared definitions for the four-bank QTR-RC scan scheduler:
//   - utility pulse array geometry (MXCLK, U10CLK, M10CLK indices)
//   - scheduler FSM state encoding (QS_IDLE..QS_DONE)
//   - register addresses and the autosend byte count
//   - counter widths used by the timing engine
// -----------------------------------------------------------------------------
package qtr_scan_sched_pkg;

    // Utility pulse array: clocks[MXCLK:0], one-cycle pulses at fixed rates.
    localparam int MXCLK  = 7;
    localparam int U10CLK = 2;   // 10 us pulse
    localparam int M10CLK = 4;   // 10 ms pulse

    // Timing engine counter widths.
    localparam int CHG_W  = 4;
    localparam int SENS_W = 8;

    typedef enum logic [2:0] {
        QS_IDLE     = 3'd0,
        QS_SELECT   = 3'd1,
        QS_CHARGING = 3'd2,
        QS_SENSING  = 3'd3,
        QS_DONE     = 3'd4
    } qs_state_t;

    // Register addresses (ADR_I[2:0]); 4..7 are sens[0..3].
    localparam logic [2:0] ADR_VAL01    = 3'd0;
    localparam logic [2:0] ADR_VAL23    = 3'd1;
    localparam logic [2:0] ADR_ENABLE   = 3'd2;
    localparam logic [2:0] ADR_POLLTIME = 3'd3;

    // Bytes the host should read when autosend is flagged.
    localparam logic [7:0] AUTOSEND_CNT = 8'h02;

endpackage

// File: rtl/qtr_scan_sched_sense_engine.sv
// -----------------------------------------------------------------------------
// qtr_sense_engine
// Charge/sense timing for one bank at a time.
//   clk, rst_n : system clock, asynchronous active-low reset
//   start      : one-cycle request to begin a charge/sense sequence
//   sens       : sensing window length in u10 ticks (0 means 256)
//   u10clk     : 10 us utility pulse
//   charge     : high while the selected bank must be driven high
//   done       : one-cycle strobe, charge time elapsed (sensing begins)
//   sample     : one-cycle strobe, sensing window elapsed (latch pins now)
// -----------------------------------------------------------------------------
module qtr_sense_engine
    import qtr_scan_sched_pkg::*;
#(
    parameter int CHG_TICKS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SENS_W-1:0] sens,
    input  logic              u10clk,
    output logic              charge,
    output logic              sample,
    output logic              done
);

    typedef enum logic [1:0] {
        EP_IDLE   = 2'd0,
        EP_CHARGE = 2'd1,
        EP_SENSE  = 2'd2
    } eng_phase_t;

    eng_phase_t        phase, phase_nxt;
    logic [CHG_W-1:0]  chgcount, chgcount_nxt;
    logic [SENS_W-1:0] senscount, senscount_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= EP_IDLE;
            chgcount  <= CHG_W'(1);
            senscount <= SENS_W'(1);
        end else begin
            phase     <= phase_nxt;
            chgcount  <= chgcount_nxt;
            senscount <= senscount_nxt;
        end
    end

    always_comb begin
        phase_nxt     = phase;
        chgcount_nxt  = chgcount;
        senscount_nxt = senscount;
        charge        = (phase == EP_CHARGE);
        sample        = 1'b0;
        done          = 1'b0;
        case (phase)
            EP_IDLE: begin
                if (start) begin
                    phase_nxt    = EP_CHARGE;
                    chgcount_nxt = CHG_W'(1);
                end
            end
            EP_CHARGE: begin
                if (u10clk) begin
                    if (chgcount == CHG_W'(CHG_TICKS)) begin
                        done          = 1'b1;
                        phase_nxt     = EP_SENSE;
                        senscount_nxt = SENS_W'(1);
                    end else begin
                        chgcount_nxt = chgcount + CHG_W'(1);
                    end
                end
            end
            EP_SENSE: begin
                // sens is compared live, so a rewrite during sensing takes
                // effect at once; a value already passed wraps the 8-bit
                // counter (and sens == 0 yields 256 ticks the same way).
                if (u10clk) begin
                    if (senscount == sens) begin
                        sample    = 1'b1;
                        phase_nxt = EP_IDLE;
                    end else begin
                        senscount_nxt = senscount + SENS_W'(1);
                    end
                end
            end
            default: phase_nxt = EP_IDLE;
        endcase
    end

endmodule

// File: rtl/qtr_scan_sched.sv
// -----------------------------------------------------------------------------
// qtr_scan_sched
// Shares one QTR-RC charge/sense engine across four quad banks (16 pins).
// Every polltime x 10 ms it scans enabled banks 0..3, latches each bank's
// four thresholded pins, then flags autosend for the host.
//   CLK_I, RST_N_I : system clock, asynchronous active-low reset
//   WE_I, TGA_I    : write=1/read=0, register access=1/poll=0
//   STB_I, ADR_I   : peripheral select and register address
//   STALL_O, ACK_O : always 0, ack = addressed
//   DAT_I, DAT_O   : bus data in/out (DAT_O passes DAT_I when not addressed)
//   clocks         : utility pulses (M10CLK, U10CLK used)
//   pins           : bank b = pins[4b+3:4b]; driven 1 while charging, else Z
// Registers: 0 {val1,val0}, 1 {val3,val2}, 2 enable, 3 polltime, 4..7 sens.
// -----------------------------------------------------------------------------
module qtr_scan_sched
    import qtr_scan_sched_pkg::*;
#(
    parameter int CHG_TICKS = 1
) (
    input  logic             CLK_I,
    input  logic             RST_N_I,
    input  logic             WE_I,
    input  logic             TGA_I,
    input  logic             STB_I,
    input  logic [7:0]       ADR_I,
    output logic             STALL_O,
    output logic             ACK_O,
    input  logic [7:0]       DAT_I,
    output logic [7:0]       DAT_O,
    input  logic [MXCLK:0]   clocks,
    inout  wire  [15:0]      pins
);

    qs_state_t         state, state_nxt;
    logic [1:0]        bank, bank_nxt;
    logic [3:0]        pollcount, pollcount_nxt;
    logic [3:0]        enable;
    logic [3:0]        polltime;
    logic [SENS_W-1:0] sens [4];
    logic [3:0]        val [4];
    logic              data_avail;

    logic              m10clk, u10clk;
    logic              eng_start, eng_charge, eng_sample, eng_done;
    logic              val_wr, set_avail;
    logic [3:0]        val_wr_data;
    logic [3:0]        bank_pins;
    logic              myaddr, reg_rd, reg_wr, poll;
    logic [7:0]        rd_data;
    logic              unused_clocks;

    assign m10clk        = clocks[M10CLK];
    assign u10clk        = clocks[U10CLK];
    assign unused_clocks = ^clocks;

    // ---------------------------------------------------------------- bus
    assign myaddr  = STB_I && (ADR_I[7:3] == 5'd0);
    assign reg_rd  = myaddr && TGA_I && !WE_I;
    assign reg_wr  = myaddr && TGA_I && WE_I;
    assign poll    = myaddr && !TGA_I;
    assign ACK_O   = myaddr;
    assign STALL_O = 1'b0;

    always_comb begin
        rd_data = 8'h00;
        case (ADR_I[2:0])
            ADR_VAL01:    rd_data = {val[1], val[0]};
            ADR_VAL23:    rd_data = {val[3], val[2]};
            ADR_ENABLE:   rd_data = {4'h0, enable};
            ADR_POLLTIME: rd_data = {4'h0, polltime};
            default:      rd_data = sens[ADR_I[1:0]];
        endcase
    end

    always_comb begin
        if (reg_rd)
            DAT_O = rd_data;
        else if (poll && data_avail)
            DAT_O = AUTOSEND_CNT;
        else
            DAT_O = DAT_I;
    end

    // ---------------------------------------------------------------- pins
    always_comb begin
        case (bank)
            2'd0:    bank_pins = pins[3:0];
            2'd1:    bank_pins = pins[7:4];
            2'd2:    bank_pins = pins[11:8];
            default: bank_pins = pins[15:12];
        endcase
    end

    // Only the selected bank can be driven, so at most four pins are ever
    // driven. charge comes straight from a reset flop, so an asynchronous
    // reset releases the pins immediately.
    for (genvar b = 0; b < 4; b++) begin : g_pin_drv
        assign pins[4*b +: 4] = (eng_charge && (bank == 2'(b))) ? 4'hF : 4'hz;
    end

    // ---------------------------------------------------------------- engine
    qtr_sense_engine #(
        .CHG_TICKS (CHG_TICKS)
    ) u_engine (
        .clk    (CLK_I),
        .rst_n  (RST_N_I),
        .start  (eng_start),
        .sens   (sens[bank]),
        .u10clk (u10clk),
        .charge (eng_charge),
        .sample (eng_sample),
        .done   (eng_done)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state     <= QS_IDLE;
            bank      <= 2'd0;
            pollcount <= 4'd1;
        end else begin
            state     <= state_nxt;
            bank      <= bank_nxt;
            pollcount <= pollcount_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bank_nxt      = bank;
        pollcount_nxt = pollcount;
        eng_start     = 1'b0;
        val_wr        = 1'b0;
        val_wr_data   = 4'h0;
        set_avail     = 1'b0;
        case (state)
            QS_IDLE: begin
                // pollcount only advances here, so it is frozen mid-scan.
                if (m10clk && (polltime != 4'd0)) begin
                    if (pollcount == polltime) begin
                        pollcount_nxt = 4'd1;
                        bank_nxt      = 2'd0;
                        state_nxt     = QS_SELECT;
                    end else begin
                        pollcount_nxt = pollcount + 4'd1;
                    end
                end
            end
            QS_SELECT: begin
                if (enable[bank]) begin
                    eng_start = 1'b1;
                    state_nxt = QS_CHARGING;
                end else begin
                    val_wr = 1'b1;
                    if (bank != 2'd3)
                        bank_nxt = bank + 2'd1;
                    else
                        state_nxt = QS_DONE;
                end
            end
            QS_CHARGING: begin
                if (eng_done)
                    state_nxt = QS_SENSING;
            end
            QS_SENSING: begin
                if (eng_sample) begin
                    val_wr      = 1'b1;
                    val_wr_data = bank_pins;
                    if (bank != 2'd3) begin
                        bank_nxt  = bank + 2'd1;
                        state_nxt = QS_SELECT;
                    end else begin
                        state_nxt = QS_DONE;
                    end
                end
            end
            QS_DONE: begin
                set_avail = 1'b1;
                state_nxt = QS_IDLE;
            end
            default: state_nxt = QS_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- regs
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            enable     <= 4'h0;
            polltime   <= 4'h0;
            data_avail <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                sens[i] <= SENS_W'(1);
                val[i]  <= 4'h0;
            end
        end else begin
            if (val_wr)
                val[bank] <= val_wr_data;

            // A scan finishing wins over a same-cycle register read.
            if (set_avail)
                data_avail <= 1'b1;
            else if (reg_rd)
                data_avail <= 1'b0;

            if (reg_wr) begin
                case (ADR_I[2:0])
                    ADR_ENABLE:   enable   <= DAT_I[3:0];
                    ADR_POLLTIME: polltime <= DAT_I[3:0];
                    ADR_VAL01, ADR_VAL23: ;
                    default:      sens[ADR_I[1:0]] <= DAT_I;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qtr_scan_sched.sv
// -----------------------------------------------------------------------------
// tb_qtr_scan_sched
// Directed bench for qtr_scan_sched. Inputs change on the falling edge, the
// DUT samples on the rising edge; outputs are read on the falling edge.
// Utility pulses are generated by hand so every scan step is deterministic.
// -----------------------------------------------------------------------------
module tb_qtr_scan_sched;
    import qtr_scan_sched_pkg::*;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           we    = 1'b0;
    logic           tga   = 1'b0;
    logic           stb   = 1'b0;
    logic [7:0]     adr   = 8'h00;
    logic [7:0]     dat_i = 8'h00;
    logic [MXCLK:0] clocks = '0;
    wire            stall;
    wire            ack;
    wire  [7:0]     dat_o;
    wire  [15:0]    pins;

    // Sensor model: the bench drives a bank's pins only while that bank is
    // in its sensing window, never while the DUT charges it.
    logic [3:0]     tb_en  = 4'h0;
    logic [15:0]    tb_val = 16'h0000;

    int             n_assert = 0;
    int             n_fail   = 0;
    logic [7:0]     rd;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_sensor
        assign pins[4*g +: 4] = tb_en[g] ? tb_val[4*g +: 4] : 4'hz;
    end

    qtr_scan_sched #(.CHG_TICKS(1)) dut (
        .CLK_I   (clk),
        .RST_N_I (rst_n),
        .WE_I    (we),
        .TGA_I   (tga),
        .STB_I   (stb),
        .ADR_I   (adr),
        .STALL_O (stall),
        .ACK_O   (ack),
        .DAT_I   (dat_i),
        .DAT_O   (dat_o),
        .clocks  (clocks),
        .pins    (pins)
    );

    // ---------------------------------------------------------------- helpers
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] drv(input logic [3:0] p);
        return {7'd0, (p === 4'hF)};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_bus();
        stb = 1'b0; tga = 1'b0; we = 1'b0; adr = 8'h00; dat_i = 8'h00;
    endtask

    task automatic pulse(input int idx);
        clocks[idx] = 1'b1;
        @(negedge clk);
        clocks[idx] = 1'b0;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        stb = 1'b1; tga = 1'b1; we = 1'b1; adr = a; dat_i = d;
        @(negedge clk);
        clear_bus();
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        stb = 1'b1; tga = 1'b1; we = 1'b0; adr = a; dat_i = 8'h00;
        #1 d = dat_o;
        @(negedge clk);
        clear_bus();
    endtask

    task automatic bus_poll(output logic [7:0] d);
        stb = 1'b1; tga = 1'b0; we = 1'b0; adr = 8'h00; dat_i = 8'h00;
        #1 d = dat_o;
        @(negedge clk);
        clear_bus();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- steps
    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset values and bus decode
        bus_read(8'h00, rd); check("rst_reg0", rd, 8'h00);
        bus_read(8'h02, rd); check("rst_enable", rd, 8'h00);
        bus_read(8'h03, rd); check("rst_polltime", rd, 8'h00);
        bus_read(8'h04, rd); check("rst_sens0", rd, 8'h01);
        bus_read(8'h07, rd); check("rst_sens3", rd, 8'h01);
        bus_poll(rd);        check("rst_poll", rd, 8'h00);
        check("rst_pins_b0", drv(pins[3:0]), 8'h00);
        stb = 1'b1; tga = 1'b1; adr = 8'h08; dat_i = 8'h5C;
        #1;
        check("foreign_ack", {7'd0, ack}, 8'h00);
        check("foreign_dat", dat_o, 8'h5C);
        adr = 8'h02;
        #1;
        check("my_ack", {7'd0, ack}, 8'h01);
        check("stall", {7'd0, stall}, 8'h00);
        @(negedge clk);
        clear_bus();

        // 1: bank0, sens0=3
        bus_write(8'h02, 8'h01);
        bus_write(8'h03, 8'h01);
        bus_write(8'h04, 8'h03);
        bus_read(8'h04, rd); check("t1_sens0_wr", rd, 8'h03);
        pulse(M10CLK);
        idle(1);
        check("t1_chg_b0", drv(pins[3:0]), 8'h01);
        check("t1_chg_b1", drv(pins[7:4]), 8'h00);
        pulse(U10CLK);
        check("t1_rel_b0", drv(pins[3:0]), 8'h00);
        tb_val = 16'h000A; tb_en = 4'b0001;
        pulse(U10CLK);
        pulse(U10CLK);
        bus_read(8'h00, rd); check("t1_reg0_2ticks", rd, 8'h00);
        bus_poll(rd);        check("t1_poll_early", rd, 8'h00);
        pulse(U10CLK);
        tb_en = 4'h0;
        idle(5);
        bus_poll(rd);        check("t1_poll", rd, 8'h02);
        // 3a: a register read clears autosend
        bus_read(8'h00, rd); check("t1_reg0", rd, 8'h0A);
        bus_poll(rd);        check("t3_poll_cleared", rd, 8'h00);

        // 2: banks 1 and 3, sens default 1
        bus_write(8'h02, 8'h0A);
        pulse(M10CLK);
        idle(2);
        check("t2_chg_b1", drv(pins[7:4]), 8'h01);
        check("t2_nodrv_b0", drv(pins[3:0]), 8'h00);
        pulse(U10CLK);
        tb_val = 16'h5A3C; tb_en = 4'b0010;
        pulse(U10CLK);
        tb_en = 4'h0;
        idle(2);
        check("t2_chg_b3", drv(pins[15:12]), 8'h01);
        check("t2_nodrv_b2", drv(pins[11:8]), 8'h00);
        pulse(U10CLK);
        tb_en = 4'b1000;
        pulse(U10CLK);
        tb_en = 4'h0;
        // 3b: this read lands in the DONE cycle; autosend must survive it
        bus_read(8'h00, rd); check("t2_reg0", rd, 8'h30);
        bus_poll(rd);        check("t3_read_at_done", rd, 8'h02);
        bus_read(8'h01, rd); check("t2_reg1", rd, 8'h50);
        bus_poll(rd);        check("t2_poll_cleared", rd, 8'h00);

        // 4: sens2=0 (256 ticks), polltime=3
        bus_write(8'h02, 8'h04);
        bus_write(8'h06, 8'h00);
        bus_write(8'h03, 8'h03);
        pulse(M10CLK); idle(3); check("t4_tick1", drv(pins[11:8]), 8'h00);
        pulse(M10CLK); idle(3); check("t4_tick2", drv(pins[11:8]), 8'h00);
        pulse(M10CLK); idle(3); check("t4_tick3", drv(pins[11:8]), 8'h01);
        pulse(M10CLK);  // mid-scan tick, must not advance pollcount
        pulse(U10CLK);
        check("t4_rel_b2", drv(pins[11:8]), 8'h00);
        tb_val = 16'h0900; tb_en = 4'b0100;
        repeat (255) pulse(U10CLK);
        bus_read(8'h01, rd); check("t4_reg1_255", rd, 8'h50);
        pulse(U10CLK);
        tb_en = 4'h0;
        idle(3);
        bus_poll(rd);        check("t4_poll", rd, 8'h02);
        bus_read(8'h01, rd); check("t4_reg1_256", rd, 8'h09);
        pulse(M10CLK); idle(3); check("t4_next1", drv(pins[11:8]), 8'h00);
        pulse(M10CLK); idle(3); check("t4_next2", drv(pins[11:8]), 8'h00);
        pulse(M10CLK); idle(3); check("t4_next3", drv(pins[11:8]), 8'h01);

        // 5: reset while bank2 is charging
        #2 rst_n = 1'b0;
        #1 check("t5_pins_z", drv(pins[11:8]), 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(8'h02, rd); check("t5_enable", rd, 8'h00);
        bus_read(8'h03, rd); check("t5_polltime", rd, 8'h00);
        bus_read(8'h06, rd); check("t5_sens2", rd, 8'h01);
        bus_read(8'h01, rd); check("t5_reg1", rd, 8'h00);
        bus_poll(rd);        check("t5_poll", rd, 8'h00);
        pulse(M10CLK); idle(3);
        check("t5_noscan", drv(pins[11:8]), 8'h00);
        bus_poll(rd);        check("t5_poll_after", rd, 8'h00);

        // 6: polltime cleared mid-scan
        bus_write(8'h02, 8'h01);
        bus_write(8'h03, 8'h01);
        pulse(M10CLK);
        idle(1);
        check("t6_chg_b0", drv(pins[3:0]), 8'h01);
        bus_write(8'h03, 8'h00);
        pulse(U10CLK);
        tb_val = 16'h0006; tb_en = 4'b0001;
        pulse(U10CLK);
        tb_en = 4'h0;
        idle(5);
        bus_poll(rd);        check("t6_poll", rd, 8'h02);
        bus_read(8'h00, rd); check("t6_reg0", rd, 8'h06);
        for (int i = 0; i < 10; i++) begin
            pulse(M10CLK);
            idle(1);
            check("t6_noscan", drv(pins[3:0]), 8'h00);
        end
        idle(5);
        bus_poll(rd);        check("t6_poll_end", rd, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
